// File: rtl/trian_data_check_if.sv
// Sample bus from the SDRAM read FIFO into the triangle-pattern checker.
// The FIFO side drives through master; the checker listens through slave.
interface trian_data_check_if #(
  parameter int dinsize = 320
);
  logic               DIN_VALID;
  logic [dinsize-1:0] DIN;

  modport master (output DIN_VALID, DIN);
  modport slave  (input  DIN_VALID, DIN);
endinterface

// File: rtl/trian_data_check.sv
// Receive-side checker for the triangle test pattern. It locks onto a stream
// whose lanes all count 0..MAX..0 together, then compares every valid word
// with the predicted next value. It reports error pulses, saturating error and
// sample counts, and the mask of lanes that were wrong on the latest error.
module trian_data_check #(
  parameter int batchsize = 10,
  parameter int batchnum  = 32,
  parameter int dinsize   = batchsize * batchnum
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CLR,
  trian_data_check_if.slave   bus,
  output logic                LOCKED,
  output logic                ERR,
  output logic [31:0]         ERR_CNT,
  output logic [31:0]         SAMPLE_CNT,
  output logic [batchnum-1:0] ERR_LANES
);

  localparam logic [batchsize-1:0] MAX  = '1;
  localparam logic [batchsize-1:0] ZERO = '0;
  localparam logic [batchsize-1:0] ONE  = batchsize'(1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ARMED, ST_LOCKED} state_t;
  typedef enum logic       {DIR_UP, DIR_DOWN} dir_t;

  state_t               state;
  dir_t                 dir;
  logic [batchsize-1:0] last;

  logic [batchsize-1:0] lane0;
  logic [batchsize-1:0] expected;
  logic                 consistent;
  logic [batchnum-1:0]  miss;

  // Classify the incoming word: lanes equal to lane 0, and lanes off the prediction.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no latch is inferred.
    lane0      = bus.DIN[batchsize-1:0];
    expected   = (dir == DIR_UP) ? last + ONE : last - ONE;
    consistent = 1'b1;
    miss       = '0;
    for (int i = 0; i < batchnum; i++) begin
      if (bus.DIN[i*batchsize +: batchsize] != lane0) consistent = 1'b0;
      miss[i] = (bus.DIN[i*batchsize +: batchsize] != expected);
    end
  end

  // Lock/track state machine with registered status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: state and outputs use non-blocking assignments so every flop updates from pre-edge values.
    if (!RST_N) begin
      state      <= ST_UNLOCKED;
      dir        <= DIR_UP;
      last       <= '0;
      LOCKED     <= 1'b0;
      ERR        <= 1'b0;
      ERR_CNT    <= '0;
      SAMPLE_CNT <= '0;
      ERR_LANES  <= '0;
    end else if (CLR) begin
      state      <= ST_UNLOCKED;
      dir        <= DIR_UP;
      last       <= '0;
      LOCKED     <= 1'b0;
      ERR        <= 1'b0;
      ERR_CNT    <= '0;
      SAMPLE_CNT <= '0;
      ERR_LANES  <= '0;
    end else begin
      ERR <= 1'b0;
      if (bus.DIN_VALID) begin
        case (state)
          ST_UNLOCKED: begin
            if (consistent) begin
              last  <= lane0;
              state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (!consistent) begin
              state <= ST_UNLOCKED;
            end else if (last != MAX && lane0 == last + ONE) begin
              state  <= ST_LOCKED;
              LOCKED <= 1'b1;
              last   <= lane0;
              dir    <= (lane0 == MAX) ? DIR_DOWN : DIR_UP;
            end else if (last != ZERO && lane0 == last - ONE) begin
              state  <= ST_LOCKED;
              LOCKED <= 1'b1;
              last   <= lane0;
              dir    <= (lane0 == ZERO) ? DIR_UP : DIR_DOWN;
            end else begin
              last <= lane0;
            end
          end
          ST_LOCKED: begin
            if (SAMPLE_CNT != '1) SAMPLE_CNT <= SAMPLE_CNT + 32'd1;
            if (miss == '0) begin
              last <= expected;
              if (dir == DIR_UP && expected == MAX)         dir <= DIR_DOWN;
              else if (dir == DIR_DOWN && expected == ZERO) dir <= DIR_UP;
            end else begin
              ERR       <= 1'b1;
              ERR_LANES <= miss;
              LOCKED    <= 1'b0;
              if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 32'd1;
              if (consistent) begin
                last  <= lane0;
                state <= ST_ARMED;
              end else begin
                state <= ST_UNLOCKED;
              end
            end
          end
          default: begin
            state  <= ST_UNLOCKED;
            LOCKED <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trian_data_check.sv
// Self-checking bench for trian_data_check: directed endpoint/error scenarios
// plus randomized streams, all compared against a behavioural model.
module tb_trian_data_check;

  localparam int BS  = 10;
  localparam int BN  = 32;
  localparam int DW  = BS * BN;
  localparam int MX  = (1 << BS) - 1;
  localparam int PER = 2 * MX;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLR   = 1'b0;
  logic          LOCKED;
  logic          ERR;
  logic [31:0]   ERR_CNT;
  logic [31:0]   SAMPLE_CNT;
  logic [BN-1:0] ERR_LANES;

  trian_data_check_if #(.dinsize(DW)) bus ();

  trian_data_check #(.batchsize(BS), .batchnum(BN), .dinsize(DW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CLR        (CLR),
    .bus        (bus.slave),
    .LOCKED     (LOCKED),
    .ERR        (ERR),
    .ERR_CNT    (ERR_CNT),
    .SAMPLE_CNT (SAMPLE_CNT),
    .ERR_LANES  (ERR_LANES)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = hunting, 1 = one candidate seen, 2 = tracking.
  int          m_mode, m_last, m_step;
  bit          m_err;
  logic [31:0] m_errs, m_samples, m_mask;

  function automatic void model_reset();
    m_mode = 0; m_last = 0; m_step = 1; m_err = 0;
    m_errs = 0; m_samples = 0; m_mask = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [DW-1:0] d);
    int  ln[BN];
    bit  cons;
    int  e;
    logic [31:0] mk;
    m_err = 0;
    if (!v) return;
    cons = 1;
    for (int i = 0; i < BN; i++) begin
      ln[i] = int'(d[i*BS +: BS]);
      if (ln[i] != ln[0]) cons = 0;
    end
    if (m_mode == 0) begin
      if (cons) begin m_last = ln[0]; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (!cons) m_mode = 0;
      else begin
        if (ln[0] - m_last == 1 || m_last - ln[0] == 1) begin
          m_step = ln[0] - m_last;
          m_mode = 2;
        end
        m_last = ln[0];
        if (m_mode == 2 && m_last == MX) m_step = -1;
        if (m_mode == 2 && m_last == 0)  m_step = 1;
      end
    end else begin
      e = m_last + m_step;
      if (m_samples != 32'hFFFF_FFFF) m_samples++;
      mk = 0;
      for (int i = 0; i < BN; i++) mk[i] = (ln[i] != e);
      if (mk == 0) begin
        m_last = e;
        if (m_last == MX) m_step = -1;
        if (m_last == 0)  m_step = 1;
      end else begin
        m_err  = 1;
        m_mask = mk;
        if (m_errs != 32'hFFFF_FFFF) m_errs++;
        if (cons) begin m_last = ln[0]; m_mode = 1; end
        else m_mode = 0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] word_of(input int v);
    logic [DW-1:0] w;
    for (int i = 0; i < BN; i++) w[i*BS +: BS] = BS'(v);
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < BN; i++) w[i*BS +: BS] = BS'($urandom);
    return w;
  endfunction

  // Triangle generator value at sample index k.
  function automatic int tri_at(input int k);
    int t;
    t = k % PER;
    return (t <= MX) ? t : PER - t;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".locked"},     64'(LOCKED),     64'(m_mode == 2));
    check({tag, ".err"},        64'(ERR),        64'(m_err));
    check({tag, ".err_cnt"},    64'(ERR_CNT),    64'(m_errs));
    check({tag, ".sample_cnt"}, 64'(SAMPLE_CNT), 64'(m_samples));
    check({tag, ".err_lanes"},  64'(ERR_LANES),  64'(m_mask));
  endtask

  task automatic cycle(input string tag, input bit v, input logic [DW-1:0] d);
    bus.DIN_VALID = v;
    bus.DIN       = d;
    @(posedge CLK);
    if (!RST_N || CLR) model_reset();
    else model_step(v, d);
    #1;
    compare_all(tag);
  endtask

  // Clear pulse with a valid word present, so clear priority is exercised.
  task automatic do_clr();
    CLR = 1'b1;
    cycle("clr", 1'b1, word_of(5));
    CLR = 1'b0;
  endtask

  int nvalid;
  int k0;
  int kk;
  int v;
  logic [DW-1:0] w;

  initial begin
    bus.DIN_VALID = 1'b0;
    bus.DIN       = '0;
    model_reset();
    #2;
    compare_all("reset");
    repeat (2) @(posedge CLK);
    #1;
    compare_all("reset_held");
    RST_N = 1'b1;

    // Generator stream from reset, DIN_VALID held high.
    for (int k = 0; k < 5000; k++) cycle("gen", 1'b1, word_of(tri_at(k)));
    check("gen_sample_total", 64'(SAMPLE_CNT), 64'd4998);
    check("gen_err_total",    64'(ERR_CNT),    64'd0);

    // Top endpoint: lock on MAX turns direction down.
    do_clr();
    cycle("top", 1'b1, word_of(MX - 1));
    cycle("top", 1'b1, word_of(MX));
    check("top_locked", 64'(LOCKED), 64'd1);
    cycle("top", 1'b1, word_of(MX - 1));
    check("top_turn_err", 64'(ERR), 64'd0);
    cycle("top", 1'b1, word_of(MX - 2));

    // Bottom endpoint: lock on 0 turns direction up.
    do_clr();
    cycle("bot", 1'b1, word_of(1));
    cycle("bot", 1'b1, word_of(0));
    check("bot_locked", 64'(LOCKED), 64'd1);
    cycle("bot", 1'b1, word_of(1));
    check("bot_turn_err", 64'(ERR), 64'd0);
    cycle("bot", 1'b1, word_of(2));

    // Single bad lane while expecting 500.
    do_clr();
    cycle("lane7", 1'b1, word_of(498));
    cycle("lane7", 1'b1, word_of(499));
    w = word_of(500);
    w[7*BS +: BS] = 10'h1F5;
    cycle("lane7", 1'b1, w);
    check("lane7_err",    64'(ERR),       64'd1);
    check("lane7_cnt",    64'(ERR_CNT),   64'd1);
    check("lane7_mask",   64'(ERR_LANES), 64'h80);
    check("lane7_locked", 64'(LOCKED),    64'd0);
    cycle("lane7", 1'b1, word_of(501));
    cycle("lane7", 1'b1, word_of(502));
    check("lane7_relock", 64'(LOCKED), 64'd1);

    // Consistent jump while expecting 300 re-arms, next step relocks.
    do_clr();
    cycle("jump", 1'b1, word_of(298));
    cycle("jump", 1'b1, word_of(299));
    cycle("jump", 1'b1, word_of(305));
    check("jump_err",  64'(ERR),       64'd1);
    check("jump_mask", 64'(ERR_LANES), 64'hFFFF_FFFF);
    cycle("jump", 1'b1, word_of(306));
    check("jump_relock", 64'(LOCKED), 64'd1);
    cycle("jump", 1'b1, word_of(307));
    check("jump_cnt", 64'(ERR_CNT), 64'd1);

    // Random valid gaps on a clean stream; invalid cycles carry garbage.
    do_clr();
    k0 = $urandom_range(0, PER - 1);
    kk = 0;
    nvalid = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle("gap", 1'b1, word_of(tri_at(k0 + kk)));
        kk++;
        nvalid++;
      end else begin
        cycle("gap", 1'b0, rand_word());
      end
    end
    check("gap_samples", 64'(SAMPLE_CNT), 64'(nvalid - 2));
    check("gap_errs",    64'(ERR_CNT),    64'd0);

    // Random corruptions and phase jumps against the model.
    do_clr();
    k0 = $urandom_range(0, PER - 1);
    for (int c = 0; c < 1500; c++) begin
      w = word_of(tri_at(k0));
      v = $urandom_range(0, 31);
      if (v == 0) k0 = $urandom_range(0, PER - 1);
      else if (v < 3) w[$urandom_range(0, BN - 1)*BS +: BS] = BS'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        cycle("rand", 1'b1, w);
        k0++;
      end else begin
        cycle("rand", 1'b0, rand_word());
      end
    end

    // Build ERR_CNT=3, then asynchronous reset mid-cycle.
    do_clr();
    cycle("arst", 1'b1, word_of(10));
    cycle("arst", 1'b1, word_of(11));
    for (int j = 0; j < 3; j++) begin
      cycle("arst", 1'b1, word_of(50 + 40 * j));
      cycle("arst", 1'b1, word_of(51 + 40 * j));
    end
    check("arst_cnt3", 64'(ERR_CNT), 64'd3);
    cycle("arst", 1'b1, word_of(132));
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all("arst_now");
    check("arst_cnt0", 64'(ERR_CNT), 64'd0);
    cycle("arst_hold", 1'b1, word_of(133));
    cycle("arst_hold", 1'b1, word_of(134));
    #2;
    RST_N = 1'b1;
    cycle("arst_relock", 1'b1, word_of(200));
    cycle("arst_relock", 1'b1, word_of(201));
    check("arst_relocked", 64'(LOCKED), 64'd1);
    cycle("arst_relock", 1'b1, word_of(202));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trian_data_check.md
# trian_data_check

Receive-side checker for the triangle test-pattern stream used in the SDRAM readout demo. It consumes the wide lane-packed word read back from SDRAM and locks onto the triangle sequence: every lane counts 0,1,…,2^batchsize−1, then back down to 1, then 0, repeating with period 2·(2^batchsize−1), and all lanes are identical. After lock it checks every subsequent valid word against the predicted value and reports errors, an error count, a sample count and the failing-lane mask. It sits after the SDRAM read FIFO and in front of status readout to the host.

## Interface
- batchsize, 10, bit width of one lane; MAX = 2^batchsize−1
- batchnum, 32, number of lanes
- dinsize, batchnum·batchsize, total data width
- CLK  in  1  single clock; all logic rising-edge
- RST_N  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous clear of counters, mask and lock; same effect as reset
- DIN_VALID  in  1  DIN holds a sample this cycle
- DIN  in  dinsize  lane i = DIN[i·batchsize +: batchsize]
- LOCKED  out  1  checker is tracking the sequence
- ERR  out  1  one-cycle pulse per detected error while locked
- ERR_CNT  out  32  errors detected, saturating at 0xFFFFFFFF
- SAMPLE_CNT  out  32  samples compared while locked, saturating
- ERR_LANES  out  batchnum  bit i set if lane i ≠ expected on the most recent error; held until next error/CLR

## Operation
- Internal state: FSM {UNLOCKED, ARMED, LOCKED}, last value L (batchsize bits), next-step direction D (UP/DOWN).
- Consistent word: all lanes equal lane 0. Only cycles with DIN_VALID=1 advance anything; DIN is ignored otherwise.
- UNLOCKED: consistent word → L=lane0, go ARMED. Inconsistent → stay.
- ARMED: inconsistent → UNLOCKED. Consistent b with L<MAX and b=L+1 → LOCKED, D=UP, L=b. Consistent b with L>0 and b=L−1 → LOCKED, D=DOWN, L=b. Any other consistent b → L=b, stay ARMED.
- Direction turn, applied whenever L is updated in LOCKED or on entry: if D=UP and new L=MAX → D=DOWN; if D=DOWN and new L=0 → D=UP.
- LOCKED: expected E = (D=UP) ? L+1 : L−1 (no wrap possible because of turn rule). SAMPLE_CNT++ on every valid word.
  - All lanes = E → L=E, apply turn rule, stay LOCKED.
  - Otherwise → ERR=1, ERR_CNT++, ERR_LANES[i] = (lane i ≠ E). If word consistent → L=lane0, go ARMED; else → UNLOCKED.
- Counters saturate; no wrap. Errors are never counted outside LOCKED.
- CLR and RST_N have identical effect; CLR takes priority over a same-cycle DIN_VALID.

## Timing
- Reset values: LOCKED=0, ERR=0, ERR_CNT=0, SAMPLE_CNT=0, ERR_LANES=0, FSM=UNLOCKED, L=0, D=UP.
- All outputs registered; result of a sample at edge n is visible after edge n+1 (1-cycle latency).
- LOCKED rises one cycle after the second consistent adjacent sample; falls in the same cycle ERR pulses.
- Back-to-back valid words (DIN_VALID held high) are supported at full rate; arbitrary gaps allowed, expectation does not advance over gaps.
- RST_N asserted mid-stream clears immediately (asynchronous); relock requires two new valid samples after release.
- Endpoints: in LOCKED with L=MAX−1, D=UP: MAX expected, then MAX−1. With L=1, D=DOWN: 0 expected, then 1.

## Test plan
- Generator stream (batchsize 10, 32 lanes) from reset, DIN_VALID=1 for 5000 cycles → LOCKED after 2nd sample, ERR never pulses, ERR_CNT=0, SAMPLE_CNT=4998.
- Start mid-stream at 1022 (up) then 1023, 1022 → locks on 1023 with D turned to DOWN, 1022 accepted; same for 1,0,1 at bottom.
- While locked expecting 500, drive lane 7 = 0x1F5 others 500 → ERR pulse, ERR_CNT=1, ERR_LANES=0x80, LOCKED=0 (UNLOCKED); relock after two good samples.
- While locked expecting 300, drive all lanes 305 → ERR, ERR_LANES all ones, ARMED; next 306 → LOCKED, no further errors.
- Locked stream with random DIN_VALID gaps (~50% duty) → no errors, SAMPLE_CNT equals valid count minus 2.
- Pulse CLR, then RST_N low mid-stream with ERR_CNT=3 → all outputs return to reset values immediately/next edge; relock verified.
